// File: rtl/cache_writeback_buffer_if.sv
// Bus bundle between the cache write-back buffer, the L1 cache (upstream)
// and physical memory (downstream). The master side is the environment:
// it drives upstream requests and memory responses.
interface cache_writeback_buffer_if #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned LINE_WIDTH = 128
);
   logic [ADDR_WIDTH-1:0] up_address;
   logic [LINE_WIDTH-1:0] up_wdata;
   logic                  up_read;
   logic                  up_write;
   logic [LINE_WIDTH-1:0] up_rdata;
   logic                  up_resp;
   logic [ADDR_WIDTH-1:0] pmem_address;
   logic [LINE_WIDTH-1:0] pmem_wdata;
   logic                  pmem_read;
   logic                  pmem_write;
   logic [LINE_WIDTH-1:0] pmem_rdata;
   logic                  pmem_resp;

   modport master (
      output up_address, up_wdata, up_read, up_write, pmem_rdata, pmem_resp,
      input  up_rdata, up_resp, pmem_address, pmem_wdata, pmem_read, pmem_write
   );

   modport slave (
      input  up_address, up_wdata, up_read, up_write, pmem_rdata, pmem_resp,
      output up_rdata, up_resp, pmem_address, pmem_wdata, pmem_read, pmem_write
   );
endinterface

// File: rtl/cache_writeback_buffer.sv
// Single-entry write-back line buffer. Evicted lines are accepted in one
// cycle and drained to memory in the background; reads that hit the
// buffered line are served from it so memory never returns stale data.
module cache_writeback_buffer #(
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned LINE_WIDTH  = 128,
   parameter int unsigned OFFSET_BITS = 4
) (
   input logic                     clk,
   input logic                     reset_n,
   cache_writeback_buffer_if.slave bus
);
   localparam int unsigned TAG_WIDTH = ADDR_WIDTH - OFFSET_BITS;
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
      {{TAG_WIDTH{1'b1}}, {OFFSET_BITS{1'b0}}};

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_READ_MEM = 2'd1;
   localparam logic [1:0] S_DRAIN    = 2'd2;
   localparam logic [1:0] S_RESP     = 2'd3;

   logic [1:0]            r_state;
   logic [1:0]            w_next_state;
   logic                  r_valid;
   logic [TAG_WIDTH-1:0]  r_tag;
   logic [LINE_WIDTH-1:0] r_data;
   logic [LINE_WIDTH-1:0] r_rdata;
   logic [ADDR_WIDTH-1:0] w_up_line_addr;
   logic [ADDR_WIDTH-1:0] w_buf_line_addr;
   logic                  w_hit;

   assign w_up_line_addr  = bus.up_address & LINE_MASK;
   assign w_buf_line_addr = {r_tag, {OFFSET_BITS{1'b0}}};
   assign w_hit           = r_valid && (w_up_line_addr == w_buf_line_addr);

   // Next-state selection; IDLE decisions follow a fixed priority order.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.up_write) begin
               // A different line occupies the entry: drain it first and
               // leave the write pending so IDLE captures it afterwards.
               w_next_state = (r_valid && !w_hit) ? S_DRAIN : S_RESP;
            end else if (bus.up_read) begin
               w_next_state = w_hit ? S_RESP : S_READ_MEM;
            end else if (r_valid) begin
               w_next_state = S_DRAIN;
            end
         end
         S_READ_MEM: if (bus.pmem_resp) w_next_state = S_RESP;
         S_DRAIN:    if (bus.pmem_resp) w_next_state = S_IDLE;
         default:    w_next_state = S_IDLE;
      endcase
   end

   // State register plus entry/read-data updates; reset discards the entry.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_valid <= 1'b0;
         r_tag   <= '0;
         r_data  <= '0;
         r_rdata <= '0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            S_IDLE: begin
               if (bus.up_write) begin
                  if (!r_valid || w_hit) begin
                     r_valid <= 1'b1;
                     r_tag   <= bus.up_address[ADDR_WIDTH-1:OFFSET_BITS];
                     r_data  <= bus.up_wdata;
                  end
               end else if (bus.up_read && w_hit) begin
                  r_rdata <= r_data;
               end
            end
            S_READ_MEM: if (bus.pmem_resp) r_rdata <= bus.pmem_rdata;
            S_DRAIN:    if (bus.pmem_resp) r_valid <= 1'b0;
            default: ;
         endcase
      end
   end

   // Memory address follows the state: request line on a miss, buffered line on a drain.
   always_comb begin
      bus.pmem_address = '0;
      if (r_state == S_READ_MEM) begin
         bus.pmem_address = w_up_line_addr;
      end else if (r_state == S_DRAIN) begin
         bus.pmem_address = w_buf_line_addr;
      end
   end

   assign bus.pmem_wdata = r_data;
   assign bus.pmem_read  = (r_state == S_READ_MEM);
   assign bus.pmem_write = (r_state == S_DRAIN);
   assign bus.up_resp    = (r_state == S_RESP);
   assign bus.up_rdata   = r_rdata;
endmodule

// File: tb/tb_cache_writeback_buffer.sv
// Directed bench for cache_writeback_buffer: a cycle-by-cycle vector table
// plus hand-written read-miss latency and mid-drain reset sequences.
module tb_cache_writeback_buffer;
   localparam logic [127:0] Z  = '0;
   localparam logic [127:0] D0 = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
   localparam logic [127:0] D1 = 128'hDEAD_BEEF_0101_0202_0303_0404_0505_0606;
   localparam logic [127:0] D2 = 128'hA5A5_5A5A_F00D_CAFE_1234_5678_9ABC_DEF0;
   localparam logic [127:0] D3 = 128'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_fail;

   cache_writeback_buffer_if #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) bus ();

   cache_writeback_buffer #(
      .ADDR_WIDTH(16),
      .LINE_WIDTH(128),
      .OFFSET_BITS(4)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   typedef struct {
      logic         rst_n;
      logic         rd;
      logic         wr;
      logic [15:0]  addr;
      logic [127:0] wd;
      logic         presp;
      logic [127:0] prd;
      logic         e_resp;
      logic         e_pr;
      logic         e_pw;
      logic [15:0]  e_pa;
      logic [127:0] e_rd;
      logic [127:0] e_wd;
   } vec_t;

   vec_t vecs[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic add(input logic rst_n, input logic rd, input logic wr,
                      input logic [15:0] addr, input logic [127:0] wd,
                      input logic presp, input logic [127:0] prd,
                      input logic e_resp, input logic e_pr, input logic e_pw,
                      input logic [15:0] e_pa, input logic [127:0] e_rd,
                      input logic [127:0] e_wd);
      vec_t v;
      v.rst_n = rst_n; v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd;
      v.presp = presp; v.prd = prd; v.e_resp = e_resp; v.e_pr = e_pr;
      v.e_pw = e_pw; v.e_pa = e_pa; v.e_rd = e_rd; v.e_wd = e_wd;
      vecs.push_back(v);
   endtask

   // sel 0 waits for up_resp, sel 1 for pmem_write; bounded to 20 cycles.
   task automatic wait_high(input int sel, input string name);
      int   n;
      logic seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         @(negedge clk);
         #1;
         seen = (sel == 0) ? bus.up_resp : bus.pmem_write;
         n++;
      end
      check(name, {127'b0, seen}, 128'd1);
   endtask

   initial begin
      int activity;
      n_checks = 0;
      n_fail   = 0;
      reset_n  = 1'b0;
      bus.up_address = '0; bus.up_wdata = '0; bus.up_read = 1'b0; bus.up_write = 1'b0;
      bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;

      //   rst rd wr addr      wd  pr prd  resp pr pw pa        rdata wdata
      // reset
      add(0, 0, 0, 16'h0000, Z,  0, Z,   0,  0, 0, 16'h0000, Z,  Z);
      add(0, 0, 0, 16'h0000, Z,  0, Z,   0,  0, 0, 16'h0000, Z,  Z);
      // write capture into empty buffer, then background drain
      add(1, 0, 1, 16'h1234, D0, 0, Z,   0,  0, 0, 16'h0000, Z,  Z);
      add(1, 0, 1, 16'h1234, D0, 0, Z,   1,  0, 0, 16'h0000, Z,  Z);
      add(1, 0, 0, 16'h0000, Z,  0, Z,   0,  0, 0, 16'h0000, Z,  Z);
      add(1, 0, 0, 16'h0000, Z,  0, Z,   0,  0, 1, 16'h1230, Z,  D0);
      add(1, 0, 0, 16'h0000, Z,  1, Z,   0,  0, 1, 16'h1230, Z,  D0);
      add(1, 0, 0, 16'h0000, Z,  0, Z,   0,  0, 0, 16'h0000, Z,  Z);
      add(1, 0, 0, 16'h0000, Z,  0, Z,   0,  0, 0, 16'h0000, Z,  Z);
      // read hit on the buffered line before the drain starts
      add(1, 0, 1, 16'h1230, D0, 0, Z,   0,  0, 0, 16'h0000, Z,  Z);
      add(1, 0, 1, 16'h1230, D0, 0, Z,   1,  0, 0, 16'h0000, Z,  Z);
      add(1, 1, 0, 16'h123A, Z,  0, Z,   0,  0, 0, 16'h0000, Z,  Z);
      add(1, 1, 0, 16'h123A, Z,  0, Z,   1,  0, 0, 16'h0000, D0, Z);
      add(1, 0, 0, 16'h0000, Z,  0, Z,   0,  0, 0, 16'h0000, D0, Z);
      add(1, 0, 0, 16'h0000, Z,  0, Z,   0,  0, 1, 16'h1230, D0, D0);
      // read miss arriving mid-drain waits for the drain
      add(1, 1, 0, 16'h4000, Z,  0, Z,   0,  0, 1, 16'h1230, D0, D0);
      add(1, 1, 0, 16'h4000, Z,  1, Z,   0,  0, 1, 16'h1230, D0, D0);
      add(1, 1, 0, 16'h4000, Z,  0, Z,   0,  0, 0, 16'h0000, D0, Z);
      add(1, 1, 0, 16'h4000, Z,  0, Z,   0,  1, 0, 16'h4000, D0, Z);
      add(1, 1, 0, 16'h4000, Z,  1, D3,  0,  1, 0, 16'h4000, D0, Z);
      add(1, 1, 0, 16'h4000, Z,  0, Z,   1,  0, 0, 16'h0000, D3, Z);
      add(1, 0, 0, 16'h0000, Z,  0, Z,   0,  0, 0, 16'h0000, D3, Z);
      // write to a different line while full: drain first, then capture
      add(1, 0, 1, 16'h1230, D0, 0, Z,   0,  0, 0, 16'h0000, D3, Z);
      add(1, 0, 1, 16'h1230, D0, 0, Z,   1,  0, 0, 16'h0000, D3, Z);
      add(1, 0, 0, 16'h0000, Z,  0, Z,   0,  0, 0, 16'h0000, D3, Z);
      add(1, 0, 1, 16'h2000, D1, 0, Z,   0,  0, 1, 16'h1230, D3, D0);
      add(1, 0, 1, 16'h2000, D1, 0, Z,   0,  0, 1, 16'h1230, D3, D0);
      add(1, 0, 1, 16'h2000, D1, 1, Z,   0,  0, 1, 16'h1230, D3, D0);
      add(1, 0, 1, 16'h2000, D1, 0, Z,   0,  0, 0, 16'h0000, D3, Z);
      add(1, 0, 1, 16'h2000, D1, 0, Z,   1,  0, 0, 16'h0000, D3, Z);
      add(1, 0, 0, 16'h0000, Z,  0, Z,   0,  0, 0, 16'h0000, D3, Z);
      add(1, 0, 0, 16'h0000, Z,  1, Z,   0,  0, 1, 16'h2000, D3, D1);
      add(1, 0, 0, 16'h0000, Z,  0, Z,   0,  0, 0, 16'h0000, D3, Z);
      // in-place overwrite: a single drain carries the newer data
      add(1, 0, 1, 16'h1230, D0, 0, Z,   0,  0, 0, 16'h0000, D3, Z);
      add(1, 0, 1, 16'h1230, D0, 0, Z,   1,  0, 0, 16'h0000, D3, Z);
      add(1, 0, 1, 16'h1238, D2, 0, Z,   0,  0, 0, 16'h0000, D3, Z);
      add(1, 0, 1, 16'h1238, D2, 0, Z,   1,  0, 0, 16'h0000, D3, Z);
      add(1, 0, 0, 16'h0000, Z,  0, Z,   0,  0, 0, 16'h0000, D3, Z);
      add(1, 0, 0, 16'h0000, Z,  1, Z,   0,  0, 1, 16'h1230, D3, D2);
      add(1, 0, 0, 16'h0000, Z,  0, Z,   0,  0, 0, 16'h0000, D3, Z);
      add(1, 0, 0, 16'h0000, Z,  0, Z,   0,  0, 0, 16'h0000, D3, Z);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         reset_n        = vecs[i].rst_n;
         bus.up_read    = vecs[i].rd;
         bus.up_write   = vecs[i].wr;
         bus.up_address = vecs[i].addr;
         bus.up_wdata   = vecs[i].wd;
         bus.pmem_resp  = vecs[i].presp;
         bus.pmem_rdata = vecs[i].prd;
         #1;
         check($sformatf("row%0d_up_resp", i), {127'b0, bus.up_resp}, {127'b0, vecs[i].e_resp});
         check($sformatf("row%0d_pmem_read", i), {127'b0, bus.pmem_read}, {127'b0, vecs[i].e_pr});
         check($sformatf("row%0d_pmem_write", i), {127'b0, bus.pmem_write}, {127'b0, vecs[i].e_pw});
         check($sformatf("row%0d_pmem_address", i), {112'b0, bus.pmem_address}, {112'b0, vecs[i].e_pa});
         check($sformatf("row%0d_up_rdata", i), bus.up_rdata, vecs[i].e_rd);
         if (vecs[i].e_pw) begin
            check($sformatf("row%0d_pmem_wdata", i), bus.pmem_wdata, vecs[i].e_wd);
         end
      end

      // Read miss with a 4-cycle memory: up_resp one cycle after pmem_resp.
      bus.up_read    = 1'b1;
      bus.up_address = 16'h7774;
      @(negedge clk); #1;
      check("miss_pmem_read_cycle1", {127'b0, bus.pmem_read}, 128'd1);
      check("miss_pmem_address", {112'b0, bus.pmem_address}, {112'b0, 16'h7770});
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         check($sformatf("miss_wait%0d_no_resp", c), {127'b0, bus.up_resp}, 128'd0);
      end
      bus.pmem_resp  = 1'b1;
      bus.pmem_rdata = D2;
      @(negedge clk);
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = Z;
      #1;
      check("miss_up_resp", {127'b0, bus.up_resp}, 128'd1);
      check("miss_up_rdata", bus.up_rdata, D2);
      check("miss_pmem_read_low", {127'b0, bus.pmem_read}, 128'd0);
      bus.up_read    = 1'b0;
      bus.up_address = '0;

      // Reset during a drain discards the line and silences memory.
      @(negedge clk);
      bus.up_write   = 1'b1;
      bus.up_address = 16'h5550;
      bus.up_wdata   = D1;
      wait_high(0, "rst_seq_write_resp");
      bus.up_write   = 1'b0;
      bus.up_address = '0;
      bus.up_wdata   = '0;
      wait_high(1, "rst_seq_drain_start");
      check("rst_seq_drain_address", {112'b0, bus.pmem_address}, {112'b0, 16'h5550});
      reset_n = 1'b0;
      @(negedge clk); #1;
      check("rst_seq_pmem_write", {127'b0, bus.pmem_write}, 128'd0);
      check("rst_seq_pmem_address", {112'b0, bus.pmem_address}, 128'd0);
      check("rst_seq_up_rdata", bus.up_rdata, Z);
      reset_n  = 1'b1;
      activity = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk); #1;
         if (bus.pmem_write || bus.pmem_read || bus.up_resp) activity++;
      end
      check("rst_seq_quiet_after", 128'(activity), 128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
